// File: rtl/mem_responder.sv
// rtl/mem_responder.sv - CPU word RAM with post-reset zero sweep and valid/ready program loader
module mem_responder #(
   parameter int WORD_SIZE      = 16,
   parameter int ADDR_W         = 16,
   parameter int DEPTH          = 256,
   parameter bit CLEAR_ON_RESET = 1'b1
) (
   input  logic                 DCLK,
   input  logic                 RSTn,
   input  logic                 M_W,
   input  logic [ADDR_W-1:0]    MADDR,
   input  logic [WORD_SIZE-1:0] MDATAOUT,
   output logic [WORD_SIZE-1:0] MDATAIN,
   input  logic                 LD_EN,
   input  logic                 LD_VALID,
   input  logic [ADDR_W-1:0]    LD_ADDR,
   input  logic [WORD_SIZE-1:0] LD_DATA,
   output logic                 LD_READY,
   output logic [15:0]          LD_COUNT,
   output logic                 BUSY,
   output logic                 ADDR_ERR
);

   localparam int              IW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_X  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IW-1:0]   LAST_PTR = IW'(DEPTH - 1);

   typedef enum logic [1:0] {ST_CLEAR, ST_RUN, ST_LOAD} state_t;

   state_t               state_q;
   logic [IW-1:0]        clr_ptr_q;
   logic [WORD_SIZE-1:0] rdata_q;
   logic                 ld_ready_q;
   logic [15:0]          ld_count_q;
   logic [15:0]          ld_count_d;
   logic                 busy_q;
   logic                 addr_err_q;
   logic [WORD_SIZE-1:0] mem_q [DEPTH];

   logic                 cpu_in_range;
   logic                 ld_in_range;
   logic [IW-1:0]        cpu_idx;
   logic [IW-1:0]        ld_idx;
   logic                 ld_xfer;
   logic                 mem_we;
   logic [IW-1:0]        mem_waddr;
   logic [WORD_SIZE-1:0] mem_wdata;

   // Range checks use the full address so aliased high addresses are caught.
   assign cpu_in_range = {1'b0, MADDR} < DEPTH_X;
   assign ld_in_range  = {1'b0, LD_ADDR} < DEPTH_X;
   assign cpu_idx      = MADDR[IW-1:0];
   assign ld_idx       = LD_ADDR[IW-1:0];
   assign ld_xfer      = LD_VALID && ld_ready_q;
   assign ld_count_d   = (ld_count_q == 16'hFFFF) ? ld_count_q : ld_count_q + 16'd1;

   always_comb begin
      mem_we    = 1'b0;
      mem_waddr = cpu_idx;
      mem_wdata = MDATAOUT;
      if (RSTn) begin
         case (state_q)
            ST_CLEAR: begin
               mem_we    = 1'b1;
               mem_waddr = clr_ptr_q;
               mem_wdata = '0;
            end
            ST_RUN:  mem_we = M_W && cpu_in_range;
            ST_LOAD: begin
               mem_we    = ld_xfer && ld_in_range;
               mem_waddr = ld_idx;
               mem_wdata = LD_DATA;
            end
            default: mem_we = 1'b0;
         endcase
      end
   end

   always_ff @(posedge DCLK) begin
      if (mem_we) begin
         mem_q[mem_waddr] <= mem_wdata;
      end
   end

   always_ff @(posedge DCLK) begin
      if (!RSTn) begin
         state_q    <= CLEAR_ON_RESET ? ST_CLEAR : ST_RUN;
         clr_ptr_q  <= '0;
         rdata_q    <= '0;
         ld_ready_q <= 1'b0;
         ld_count_q <= '0;
         addr_err_q <= 1'b0;
         busy_q     <= CLEAR_ON_RESET;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               rdata_q   <= '0;
               clr_ptr_q <= clr_ptr_q + 1'b1;
               if (clr_ptr_q == LAST_PTR) begin
                  state_q   <= ST_RUN;
                  busy_q    <= 1'b0;
                  clr_ptr_q <= '0;
               end
            end
            ST_RUN: begin
               if (cpu_in_range) begin
                  rdata_q <= M_W ? MDATAOUT : mem_q[cpu_idx];
               end else begin
                  rdata_q    <= '0;
                  addr_err_q <= 1'b1;
               end
               if (LD_EN) begin
                  state_q    <= ST_LOAD;
                  ld_ready_q <= 1'b1;
               end
            end
            ST_LOAD: begin
               // A transfer in the cycle LD_EN drops is still taken.
               if (ld_xfer) begin
                  if (ld_in_range) begin
                     ld_count_q <= ld_count_d;
                  end else begin
                     addr_err_q <= 1'b1;
                  end
               end
               if (!LD_EN) begin
                  state_q    <= ST_RUN;
                  ld_ready_q <= 1'b0;
               end
            end
            default: state_q <= ST_RUN;
         endcase
      end
   end

   assign MDATAIN  = rdata_q;
   assign LD_READY = ld_ready_q;
   assign LD_COUNT = ld_count_q;
   assign BUSY     = busy_q;
   assign ADDR_ERR = addr_err_q;

endmodule
